axi4_lite_slave_regs: RTL and testbench

//  AXI4-Lite subordinate (responder) exposing NUM_REGS 32-bit read/write control registers.

---
 rtl/axi4_lite_pkg.sv | 42 ++++
 rtl/axi4_lite_slave_regs.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions for the register-slave block.
//   axi_resp_t   : AXI response encoding (OKAY / SLVERR)
//   w_state_t    : write-channel FSM states
//   r_state_t    : read-channel FSM states
//   apply_wstrb  : merges a write word into an old word under byte enables
package axi4_lite_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        W_ACCEPT = 1'b0,
        W_RESP   = 1'b1
    } w_state_t;

    typedef enum logic {
        R_ACCEPT = 1'b0,
        R_RESP   = 1'b1
    } r_state_t;

    // Byte k of the result comes from data when strb[k] is set, else from old_word.
    function automatic logic [AXIL_DATA_W-1:0] apply_wstrb(
        input logic [AXIL_DATA_W-1:0] old_word,
        input logic [AXIL_DATA_W-1:0] data,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < AXIL_STRB_W; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = data[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite subordinate exposing NUM_REGS 32-bit read/write registers.
// Register i lives at byte offset 4*i; addresses past the last register
// answer SLVERR (writes ignored, reads return 0).
// Ports:
//   aclk, aresetn          : clock, synchronous active-low reset
//   s_axi_aw* / s_axi_w*   : write address / write data channels
//   s_axi_b*               : write response channel
//   s_axi_ar* / s_axi_r*   : read address / read data channels
//   regs_o                 : all registers flattened, register i at [32*i+:32]
//   wr_pulse_o             : one-cycle strobe, bit i set when register i was written
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [ADDR_W-1:0]               s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [AXIL_DATA_W-1:0]          s_axi_wdata,
    input  logic [AXIL_STRB_W-1:0]          s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [ADDR_W-1:0]               s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [AXIL_DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [AXIL_DATA_W*NUM_REGS-1:0] regs_o,
    output logic [NUM_REGS-1:0]             wr_pulse_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int OFF_W = ADDR_W - 2;

    // Word offset decode; the byte lane bits addr[1:0] play no part.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2] < OFF_W'(NUM_REGS);
    endfunction

    // ---------------- register state ----------------
    logic [AXIL_DATA_W-1:0] regs_q [NUM_REGS];
    logic [AXIL_DATA_W-1:0] regs_d [NUM_REGS];

    // ---------------- write channel state ----------------
    w_state_t               w_state_q, w_state_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   aw_got_q, aw_got_d;
    logic                   w_got_q, w_got_d;
    logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
    logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
    logic [AXIL_STRB_W-1:0] wstrb_q, wstrb_d;
    logic                   bvalid_q, bvalid_d;
    axi_resp_t              bresp_q, bresp_d;
    logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;

    // ---------------- read channel state ----------------
    r_state_t               r_state_q, r_state_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    axi_resp_t              rresp_q, rresp_d;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;

    logic                   aw_hs, w_hs, ar_hs;
    logic                   aw_have, w_have;
    logic [ADDR_W-1:0]      wr_addr;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]       wr_idx, rd_idx;

    assign aw_hs   = s_axi_awvalid & awready_q;
    assign w_hs    = s_axi_wvalid & wready_q;
    assign ar_hs   = s_axi_arvalid & arready_q;
    assign aw_have = aw_got_q | aw_hs;
    assign w_have  = w_got_q | w_hs;

    // When a channel handshakes on the committing edge its live bus value is
    // used; otherwise the copy captured on an earlier edge.
    assign wr_addr = aw_hs ? s_axi_awaddr : awaddr_q;
    assign wr_data = w_hs ? s_axi_wdata : wdata_q;
    assign wr_strb = w_hs ? s_axi_wstrb : wstrb_q;
    assign wr_idx  = wr_addr[2 +: IDX_W];
    assign rd_idx  = s_axi_araddr[2 +: IDX_W];

    // Write FSM next state
    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        case (w_state_q)
            W_ACCEPT: begin
                if (aw_have && w_have) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (addr_in_range(wr_addr)) begin
                        regs_d[wr_idx]     = apply_wstrb(regs_q[wr_idx], wr_data, wr_strb);
                        wr_pulse_d[wr_idx] = 1'b1;
                        bresp_d            = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    // Also raises the readies on the first cycle out of reset.
                    aw_got_d  = aw_have;
                    w_got_d   = w_have;
                    awready_d = ~aw_have;
                    wready_d  = ~w_have;
                    if (aw_hs) begin
                        awaddr_d = s_axi_awaddr;
                    end
                    if (w_hs) begin
                        wdata_d = s_axi_wdata;
                        wstrb_d = s_axi_wstrb;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_ACCEPT;
                end
            end
            default: w_state_d = W_ACCEPT;
        endcase
    end

    // Read FSM next state; reads sample regs_q, so a same-edge write is not seen.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_ACCEPT: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                    if (addr_in_range(s_axi_araddr)) begin
                        rdata_d = regs_q[rd_idx];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_ACCEPT;
                end
            end
            default: r_state_d = R_ACCEPT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            regs_q     <= '{default: '0};
            w_state_q  <= W_ACCEPT;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            r_state_q  <= R_ACCEPT;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            w_state_q  <= w_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign wr_pulse_o    = wr_pulse_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
        assign regs_o[AXIL_DATA_W*i +: AXIL_DATA_W] = regs_q[i];
    end

    // Protection bits and byte-lane address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Testbench for axi4_lite_slave_regs: directed scenarios plus random traffic,
// checked by a scoreboard against a behavioural register-file model.
module tb_axi4_lite_slave_regs;

    localparam int ADDR_W = 32;
    localparam int NREG   = 4;
    localparam int TMO    = 50;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [2:0]        awprot = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [ADDR_W-1:0] araddr = '0;
    logic [2:0]        arprot = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [32*NREG-1:0] regs_o;
    logic [NREG-1:0]   wr_pulse_o;

    axi4_lite_slave_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NREG)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #2 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct { logic [1:0] resp; logic [3:0] pulse; } bexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    bexp_t bq[$];
    rexp_t rq[$];

    logic [31:0] model [NREG];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_hit(input logic [31:0] a);
        return (a / 4) < NREG;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return model_hit(a) ? 2'b00 : 2'b10;
    endfunction

    // Applies a write to the model and returns the strobe pattern it should produce.
    function automatic logic [3:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        int idx;
        if (!model_hit(a)) return 4'b0;
        idx  = int'(a / 4);
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        model[idx] = (model[idx] & ~mask) | (d & mask);
        return 4'(1 << idx);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_hit(a) ? model[int'(a / 4)] : 32'h0;
    endfunction

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // ---------------- handshake helpers (entered at posedge+1) ----------------
    function automatic logic rdy(input int ch);
        case (ch)
            0: return awready;
            1: return wready;
            2: return arready;
            3: return bvalid;
            default: return rvalid;
        endcase
    endfunction

    task automatic drop(input int ch);
        case (ch)
            0: awvalid = 1'b0;
            1: wvalid  = 1'b0;
            2: arvalid = 1'b0;
            3: bready  = 1'b0;
            default: rready = 1'b0;
        endcase
    endtask

    task automatic hs(input int ch);
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!rdy(ch) && n < TMO);
        if (!rdy(ch)) begin
            tests++;
            fails++;
            $display("FAIL timeout_ch%0d: handshake not seen, got 0 expected 1 within %0d cycles", ch, TMO);
        end
        @(posedge aclk);
        #1;
        drop(ch);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd);
        bexp_t e;
        e.resp  = model_resp(a);
        e.pulse = model_write(a, d, s);
        bq.push_back(e);
        fork
            begin idle(awd); awaddr = a; awvalid = 1'b1; hs(0); end
            begin idle(wd); wdata = d; wstrb = s; wvalid = 1'b1; hs(1); end
        join
        idle(bd);
        bready = 1'b1;
        hs(3);
    endtask

    task automatic do_read(input logic [31:0] a, input int rd);
        rexp_t e;
        e.data = model_read(a);
        e.resp = model_resp(a);
        rq.push_back(e);
        araddr = a;
        arvalid = 1'b1;
        hs(2);
        idle(rd);
        rready = 1'b1;
        hs(4);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic monitor();
        int aw_c = 0, w_c = 0, ar_c = 0;
        logic bv_prev = 1'b0, rv_prev = 1'b0;
        bexp_t be;
        rexp_t re;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                bv_prev = 1'b0;
                rv_prev = 1'b0;
            end else begin
                if (awvalid && awready) aw_c = cyc;
                if (wvalid && wready)   w_c  = cyc;
                if (arvalid && arready) ar_c = cyc;
                if (bvalid && !bv_prev) begin
                    if (bq.size() == 0) begin
                        check("b_unexpected", 1, 0);
                    end else begin
                        check("wr_pulse", wr_pulse_o, bq[0].pulse);
                        check("regs_after_write", regs_o, model_flat());
                        check("b_latency", cyc, ((aw_c > w_c) ? aw_c : w_c) + 1);
                    end
                end else if (wr_pulse_o != 0) begin
                    check("stray_pulse", wr_pulse_o, 0);
                end
                if (bvalid && bready && bq.size() > 0) begin
                    be = bq.pop_front();
                    check("bresp", bresp, be.resp);
                end
                if (rvalid && !rv_prev) check("r_latency", cyc, ar_c + 1);
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        check("r_unexpected", 1, 0);
                    end else begin
                        re = rq.pop_front();
                        check("rdata", rdata, re.data);
                        check("rresp", rresp, re.resp);
                    end
                end
                bv_prev = bvalid;
                rv_prev = rvalid;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bexp_t e;
        rexp_t r;
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        fork monitor(); join_none

        // Reset state
        #10;
        @(negedge aclk);
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        check("rst_regs", regs_o, 128'h0);
        check("rst_pulse", wr_pulse_o, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("readies_at_release", {awready, wready, arready}, 3'b000);
        @(negedge aclk);
        check("readies_after_release", {awready, wready, arready}, 3'b111);
        @(posedge aclk); #1;

        // 1: basic writes and readback
        do_write(32'h0, 32'hdeadbeef, 4'hf, 0, 0, 0);
        do_write(32'h4, 32'h1, 4'hf, 0, 0, 1);
        do_write(32'h8, 32'h2, 4'hf, 1, 0, 0);
        do_read(32'h0, 0);
        do_read(32'h4, 1);
        do_read(32'h8, 0);

        // 2: AW three cycles ahead of W
        do_write(32'h4, 32'h55, 4'hf, 0, 3, 0);

        // 3: partial and empty byte strobes
        do_write(32'h0, 32'hdeadbeef, 4'hf, 0, 0, 0);
        do_write(32'h0, 32'h0000ab00, 4'b0010, 0, 0, 0);
        do_read(32'h0, 0);
        do_write(32'h0, 32'h12345678, 4'b0000, 0, 0, 0);
        do_read(32'h1, 0);

        // 4: out-of-range access
        do_write(32'h10, 32'hffffffff, 4'hf, 0, 0, 0);
        do_read(32'h10, 0);
        do_read(32'h40000000, 0);

        // 5: held response blocks a queued AW
        e.resp = model_resp(32'h8);
        e.pulse = model_write(32'h8, 32'hcafe0001, 4'hf);
        bq.push_back(e);
        awaddr = 32'h8; awvalid = 1'b1; wdata = 32'hcafe0001; wstrb = 4'hf; wvalid = 1'b1;
        fork hs(0); hs(1); join
        awaddr = 32'hc; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("hold_bvalid", bvalid, 1'b1);
            check("hold_bresp", bresp, 2'b00);
            check("hold_readies", {awready, wready}, 2'b00);
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        hs(3);
        e.resp = model_resp(32'hc);
        e.pulse = model_write(32'hc, 32'hcafe0002, 4'hf);
        bq.push_back(e);
        wdata = 32'hcafe0002; wvalid = 1'b1;
        fork hs(0); hs(1); join
        bready = 1'b1;
        hs(3);

        // Read and write committing on the same edge to the same register
        r.data = model_read(32'h4);
        r.resp = 2'b00;
        rq.push_back(r);
        e.resp = 2'b00;
        e.pulse = model_write(32'h4, 32'h0badf00d, 4'hf);
        bq.push_back(e);
        awaddr = 32'h4; awvalid = 1'b1; wdata = 32'h0badf00d; wstrb = 4'hf; wvalid = 1'b1;
        araddr = 32'h4; arvalid = 1'b1;
        fork hs(0); hs(1); hs(2); join
        bready = 1'b1; rready = 1'b1;
        fork hs(3); hs(4); join

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        // 6: reset in the middle of a write
        awaddr = 32'h8; awvalid = 1'b1;
        hs(0);
        idle(1);
        aresetn = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        idle(2);
        @(negedge aclk);
        check("midrst_regs", regs_o, 128'h0);
        check("midrst_bvalid", bvalid, 1'b0);
        check("midrst_awready", awready, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        idle(2);
        do_write(32'h8, 32'h600dcafe, 4'hf, 0, 1, 0);
        do_read(32'h8, 0);
        idle(3);
        check("b_queue_drained", bq.size(), 0);
        check("r_queue_drained", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
